tid_reorder_buf: RTL
====================

TID_REORDER_BUF -- requirements
Module: tid_reorder_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of outstanding reads tracked, power of two, not below 2.
REQ-002 SHALL have parameter TID_W, default 2, width of the slave transaction id.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1, the reset; it is asynchronous and active-low.
REQ-005 SHALL have master-side inputs m_req (1), m_addr (32), m_cmd (1; 1=write, 0=read) and m_wdata (32).
REQ-006 SHALL have master-side outputs m_ack (1), m_resp (1) and m_rdata (32); read data is returned in issue order.
REQ-007 SHALL have slave-side outputs s_req (1), s_addr (32), s_cmd (1) and s_wdata (32).
REQ-008 SHALL have slave-side inputs s_ack (1) and s_reqtid (TID_W); s_reqtid is valid combinationally in the cycle of an accepted read.
REQ-009 SHALL have slave-side inputs s_resp (1), s_resptid (TID_W) and s_rdata (32); responses may arrive in any order.
REQ-010 SHALL have output err_o, 1, a sticky protocol-error flag.

Function
REQ-011 SHALL drive s_addr, s_cmd and s_wdata combinationally from m_addr, m_cmd and m_wdata.
REQ-012 SHALL drive s_req = m_req AND (m_cmd OR cnt<DEPTH).
  - cnt = number of occupied slots.
  - A read is blocked when cnt==DEPTH, even if a pop occurs in the same cycle.
REQ-013 SHALL drive m_ack = s_req AND s_ack.
REQ-014 SHALL not track writes: no slot is allocated and no m_resp is produced for a write.
REQ-015 SHALL hold a circular slot array of DEPTH entries, each storing {tid, rcvd, data}, with write pointer wp, read pointer rp and cnt; pointers wrap modulo DEPTH.
REQ-016 SHALL allocate a slot for each accepted read (m_req AND m_ack AND NOT m_cmd):
  - slot[wp] <= {s_reqtid, rcvd=0, data unchanged};
  - wp and cnt increment.
REQ-017 SHALL, on s_resp, find the single occupied slot with tid==s_resptid and rcvd==0, then set rcvd=1 and data=s_rdata.
  - If no slot matches, SHALL set err_o and discard the response.
REQ-018 SHALL set err_o on a read accept when an occupied slot already has tid==s_reqtid and rcvd==0; the slot is still allocated.
REQ-019 SHALL allow a tid to be reused while an older slot with the same tid is rcvd=1 and undelivered; matching uses only rcvd==0 slots.
REQ-020 SHALL, at each clk_i edge with cnt>0, deliver the head when either of these holds:
  - slot[rp].rcvd==1; or
  - s_resp==1 and s_resptid==slot[rp].tid with slot[rp].rcvd==0 (bypass).
  On delivery: m_resp <= 1; m_rdata <= the head data (s_rdata when bypassing); rp increments; the slot is freed.
REQ-021 SHALL otherwise register m_resp <= 0 and hold m_rdata.
REQ-022 SHALL therefore have latency of exactly 1 cycle from head-response arrival to m_resp, and throughput of 1 delivery per cycle.
REQ-023 SHALL handle allocate and deliver in the same cycle: cnt stays unchanged; both pointers advance.
REQ-024 SHALL handle a non-head s_resp and a head delivery in the same cycle: both take effect.
REQ-025 SHALL update cnt per cycle as cnt + alloc - deliver, within the range 0..DEPTH.

Reset
REQ-026 SHALL, while rst_i==0, asynchronously force:
  - m_resp=0, m_rdata=0, err_o=0;
  - wp=rp=cnt=0;
  - every rcvd=0.
REQ-027 SHALL discard outstanding reads on reset mid-operation; responses arriving after reset release SHALL set err_o.
REQ-028 SHALL keep err_o set until reset.

Verification
REQ-029 In-order: read A, s_reqtid=0; s_resp tid0 data 0x11 at cycle t -> m_resp=1, m_rdata=0x11 at t+1; cnt returns to 0.
REQ-030 Reorder: reads with tids 0,1,2; responses tid2=0xC, tid0=0xA, tid1=0xB on consecutive cycles -> m_rdata sequence 0xA, 0xB, 0xC; 0xA appears 1 cycle after the tid0 response.
REQ-031 Full: 4 reads outstanding with no responses -> 5th read sees s_req=0 and m_ack=0, while a write in the same state is passed through with m_ack=s_ack.
REQ-032 Tid reuse: tid1 received but waiting behind tid0; new read assigned tid1 -> later tid1 response fills the new slot only; err_o stays 0.
REQ-033 Errors: s_resp tid3 with nothing outstanding -> err_o=1 next cycle and sticky; no m_resp.
REQ-034 Reset mid-stream: 3 reads outstanding, rst_i pulsed low asynchronously -> m_resp=0 and cnt=0 immediately; 64 cycles of random traffic against the reordering slave afterwards SHALL match a FIFO scoreboard.

Source files
------------

// File: rtl/tid_reorder_buf.sv
// tid_reorder_buf: sits between an in-order master and a slave that tags
// reads with a transaction id and may answer them out of order. Each accepted
// read takes a slot in a circular buffer; responses are matched to slots by
// tid and the head slot is handed back to the master as soon as it has data.
// Writes pass straight through and are not tracked.
module tid_reorder_buf #(
  parameter int DEPTH = 4,
  parameter int TID_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // master side
  input  logic             m_req,
  input  logic [31:0]      m_addr,
  input  logic             m_cmd,
  input  logic [31:0]      m_wdata,
  output logic             m_ack,
  output logic             m_resp,
  output logic [31:0]      m_rdata,
  // slave side
  output logic             s_req,
  output logic [31:0]      s_addr,
  output logic             s_cmd,
  output logic [31:0]      s_wdata,
  input  logic             s_ack,
  input  logic [TID_W-1:0] s_reqtid,
  input  logic             s_resp,
  input  logic [TID_W-1:0] s_resptid,
  input  logic [31:0]      s_rdata,
  output logic             err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wp_q, rp_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DEPTH-1:0] rcvd_q;
  logic [TID_W-1:0] tid_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic             m_resp_q;
  logic [31:0]      m_rdata_q;
  logic             err_q;

  logic             full;
  logic             alloc;
  logic             head_rdy;
  logic             bypass;
  logic             deliver;
  logic             found;
  logic             resp_hit;
  logic             fill;
  logic             resp_err;
  logic             dup_err;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] idx;
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] resp_match;
  logic [DEPTH-1:0] req_match;

  // Request path is a pure pass-through; only reads are throttled by occupancy.
  assign s_addr  = m_addr;
  assign s_cmd   = m_cmd;
  assign s_wdata = m_wdata;
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign s_req   = m_req & (m_cmd | ~full);
  assign m_ack   = s_req & s_ack;
  assign alloc   = m_req & m_ack & ~m_cmd;

  // Per-slot occupancy (age relative to the head below cnt) and tid matches
  // against the incoming response and the tid of a read being accepted.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] age;
      assign age            = PTR_W'(gi) - rp_q;
      assign occ[gi]        = ({1'b0, age} < cnt_q);
      assign resp_match[gi] = occ[gi] & ~rcvd_q[gi] & (tid_q[gi] == s_resptid);
      assign req_match[gi]  = occ[gi] & ~rcvd_q[gi] & (tid_q[gi] == s_reqtid);
    end
  endgenerate

  // Choose the oldest waiting slot matching the response tid, scanning from the head.
  always_comb begin
    found   = 1'b0;
    sel_idx = rp_q;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp_q + PTR_W'(k);
      if (!found && resp_match[idx]) begin
        found   = 1'b1;
        sel_idx = idx;
      end
    end
  end

  // A response aimed at the waiting head bypasses storage and is delivered directly.
  assign resp_hit = s_resp & found;
  assign bypass   = resp_hit & (sel_idx == rp_q);
  assign fill     = resp_hit & ~bypass;
  assign resp_err = s_resp & ~found;
  assign dup_err  = alloc & (|req_match);
  assign head_rdy = (cnt_q != '0) & rcvd_q[rp_q];
  assign deliver  = head_rdy | bypass;

  // Pointers, occupancy, registered master response and the sticky error flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      m_resp_q  <= 1'b0;
      m_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (alloc)   wp_q <= wp_q + PTR_W'(1);
      if (deliver) rp_q <= rp_q + PTR_W'(1);
      cnt_q    <= cnt_q + CNT_W'(alloc) - CNT_W'(deliver);
      m_resp_q <= deliver;
      if (deliver) m_rdata_q <= bypass ? s_rdata : data_q[rp_q];
      if (resp_err || dup_err) err_q <= 1'b1;
    end
  end

  // Received flags: cleared on allocation and on delivery, set when a response fills a slot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rcvd_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && wp_q == PTR_W'(i))         rcvd_q[i] <= 1'b0;
        else if (fill && sel_idx == PTR_W'(i))  rcvd_q[i] <= 1'b1;
        else if (deliver && rp_q == PTR_W'(i))  rcvd_q[i] <= 1'b0;
      end
    end
  end

  // Slot payload storage; contents only matter while the slot is occupied.
  always_ff @(posedge clk_i) begin
    if (alloc) tid_q[wp_q]     <= s_reqtid;
    if (fill)  data_q[sel_idx] <= s_rdata;
  end

  assign m_resp  = m_resp_q;
  assign m_rdata = m_rdata_q;
  assign err_o   = err_q;

endmodule
